// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router ingress packet controller:
//   - NUM_PORTS_C  : number of output FIFOs
//   - ADDR_DROP_C  : header address value that is never routed
//   - TIMEOUT_C    : watchdog limit (cycles of unread valid data)
//   - ST_* / state_t : packet FSM state encodings
//   - busy_state() : source back-pressure decode of a state
// Used by router_pkt_ctrl and router_sync_wdog.
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int         NUM_PORTS_C = 3;
  localparam logic [1:0] ADDR_DROP_C = 2'b11;
  localparam int         TIMEOUT_C   = 30;

  // Raw encodings kept as plain constants so legacy code comparing against
  // bare 3-bit values keeps working.
  localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] ST_LOAD_DATA          = 3'd2;
  localparam logic [2:0] ST_LOAD_PARITY        = 3'd3;
  localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd4;
  localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd5;
  localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd6;
  localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd7;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = ST_DECODE_ADDRESS,
    LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
    LOAD_DATA          = ST_LOAD_DATA,
    LOAD_PARITY        = ST_LOAD_PARITY,
    FIFO_FULL_STATE    = ST_FIFO_FULL_STATE,
    LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR
  } state_t;

  // The source may only advance in the two states that consume a byte
  // straight from data_in: header decode and payload streaming.
  function automatic logic busy_state(input state_t s);
    return !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
  endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// ---------------------------------------------------------------------------
// router_sync_wdog
// Port-side helper for the router packet controller:
//   - latches the destination address of the current packet
//   - decodes the one-hot FIFO write enable from the FSM write request
//   - produces vld_out = ~fifo_empty per port
//   - selects full/empty/soft-reset of the latched port for the FSM
//   - per-port watchdog raising a one-cycle soft_reset when a port holds
//     valid data unread for TIMEOUT cycles
// Build option: ROUTER_CTRL_WATCHDOG_EN builds the watchdog counters; when
// undefined soft_reset_o is tied low.
// Ports:
//   clock, reset       clock and synchronous active-high reset
//   latch_addr_i       capture hdr_addr_i into the address register
//   hdr_addr_i         header address from the source byte
//   write_req_i        FSM wants a FIFO write this cycle
//   fifo_full_i/empty_i/read_enb_i  per-port FIFO status and read strobes
//   addr_o             latched destination port
//   write_enb_o        one-hot FIFO write enables
//   vld_out_o          per-port data-available flags
//   soft_reset_o       per-port one-cycle soft reset pulses
//   full_sel_o, empty_sel_o, srst_sel_o  status of the latched port
// ---------------------------------------------------------------------------
module router_sync_wdog
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_C,
  parameter int TIMEOUT   = TIMEOUT_C
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 latch_addr_i,
  input  logic [1:0]           hdr_addr_i,
  input  logic                 write_req_i,
  input  logic [NUM_PORTS-1:0] fifo_full_i,
  input  logic [NUM_PORTS-1:0] fifo_empty_i,
  input  logic [NUM_PORTS-1:0] read_enb_i,
  output logic [1:0]           addr_o,
  output logic [NUM_PORTS-1:0] write_enb_o,
  output logic [NUM_PORTS-1:0] vld_out_o,
  output logic [NUM_PORTS-1:0] soft_reset_o,
  output logic                 full_sel_o,
  output logic                 empty_sel_o,
  output logic                 srst_sel_o
);

  logic [1:0] addr_q;
  logic [1:0] addr_d;

  assign addr_d = latch_addr_i ? hdr_addr_i : addr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= 2'b00;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      // Only the latched port is ever enabled, so at most one bit is set.
      assign write_enb_o[gi] = write_req_i && (addr_q == 2'(gi));
      assign vld_out_o[gi]   = ~fifo_empty_i[gi];
    end
  endgenerate

  always_comb begin
    full_sel_o  = 1'b0;
    empty_sel_o = 1'b0;
    srst_sel_o  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (addr_q == 2'(k)) begin
        full_sel_o  = fifo_full_i[k];
        empty_sel_o = fifo_empty_i[k];
        srst_sel_o  = soft_reset_o[k];
      end
    end
  end

`ifdef ROUTER_CTRL_WATCHDOG_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_wdog
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          pulse_q;
      logic          pulse_d;

      // A read (or an empty FIFO) always restarts the count, including on
      // the terminal cycle, so a late read suppresses the pulse.
      always_comb begin
        cnt_d   = cnt_q + 1'b1;
        pulse_d = 1'b0;
        if (read_enb_i[gi] || !vld_out_o[gi]) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          pulse_q <= pulse_d;
        end
      end

      assign soft_reset_o[gi] = pulse_q;
    end
  endgenerate
`else
  logic unused_wdog;
  assign unused_wdog  = ^{read_enb_i, 32'(TIMEOUT)};
  assign soft_reset_o = '0;
`endif

endmodule

// File: rtl/router_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// router_pkt_ctrl
// Packet-level controller for the 1x3 router ingress. Decodes the header
// address, sequences header/payload/parity writes into the selected output
// FIFO, stalls while that FIFO is full and (optionally) runs the per-output
// soft-reset watchdog through router_sync_wdog.
// Build option: ROUTER_CTRL_WATCHDOG_EN enables the watchdog and the
// "soft reset of the active port aborts the packet" transition. Undefined:
// soft_reset is tied low and the FSM ignores it.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   pkt_valid, data_in  source interface (header address = data_in[1:0])
//   parity_done         register block captured the parity byte
//   low_pkt_valid       pkt_valid fell while stalled on a full FIFO
//   fifo_full/empty     per-FIFO status
//   read_enb            per-FIFO destination read strobe
//   write_enb           one-hot FIFO write enable
//   ifd_state           header-write marker (FIFO data bit 8)
//   soft_reset          per-FIFO one-cycle soft reset
//   vld_out             ~fifo_empty per port
//   fifo_full_sel       full flag of the latched port
//   busy                source must hold its byte
//   detect_add, ld_state, laf_state, full_state, lp_state, rst_int_reg
//                       state decodes for the register/parity block
// All outputs are decodes of the state register (plus selected FIFO status).
// ---------------------------------------------------------------------------
module router_pkt_ctrl
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_C,
  parameter int TIMEOUT   = TIMEOUT_C
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 ifd_state,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic                 fifo_full_sel,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 lp_state,
  output logic                 rst_int_reg
);

  state_t     state_q;
  state_t     state_d;

  logic [1:0] hdr_addr;
  logic       hdr_valid;
  logic       hdr_empty;
  logic       latch_addr;
  logic       write_req;
  logic [1:0] addr_sel;
  logic       full_sel;
  logic       empty_sel;
  logic       srst_sel;

  // Only the two address bits of the source byte matter here.
  logic unused_data;
  assign unused_data = ^data_in[7:2];

  assign hdr_addr  = data_in[1:0];
  assign hdr_valid = (hdr_addr != ADDR_DROP_C) && (32'(hdr_addr) < NUM_PORTS);

  // Empty flag of the port named by the header byte currently on data_in,
  // needed before the address register has been loaded.
  always_comb begin
    hdr_empty = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (hdr_addr == 2'(k)) begin
        hdr_empty = fifo_empty[k];
      end
    end
  end

  assign latch_addr = detect_add && pkt_valid && hdr_valid;

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && hdr_valid) begin
          state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_sel) begin
          state_d = LOAD_FIRST_DATA;
        end
      end
      LOAD_FIRST_DATA: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (full_sel) begin
          state_d = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!full_sel) begin
          state_d = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_PARITY: begin
        state_d = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        state_d = full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: begin
        state_d = DECODE_ADDRESS;
      end
    endcase
`ifdef ROUTER_CTRL_WATCHDOG_EN
    // A soft reset of the active FIFO discards the packet in flight.
    if (srst_sel) begin
      state_d = DECODE_ADDRESS;
    end
`endif
  end

`ifndef ROUTER_CTRL_WATCHDOG_EN
  logic unused_srst;
  assign unused_srst = srst_sel;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------
  // State decodes
  // --------------------------------------------------------------------
  assign detect_add  = (state_q == DECODE_ADDRESS);
  assign ifd_state   = (state_q == LOAD_FIRST_DATA);
  assign ld_state    = (state_q == LOAD_DATA);
  assign laf_state   = (state_q == LOAD_AFTER_FULL);
  assign full_state  = (state_q == FIFO_FULL_STATE);
  assign lp_state    = (state_q == LOAD_PARITY);
  assign rst_int_reg = (state_q == CHECK_PARITY_ERROR);
  assign busy        = busy_state(state_q);

  // Streaming payload must pause the same cycle the FIFO reports full.
  assign write_req = ifd_state || (ld_state && !full_sel) || lp_state || laf_state;

  assign fifo_full_sel = full_sel;

  router_sync_wdog #(
    .NUM_PORTS (NUM_PORTS),
    .TIMEOUT   (TIMEOUT)
  ) u_sync_wdog (
    .clock        (clock),
    .reset        (reset),
    .latch_addr_i (latch_addr),
    .hdr_addr_i   (hdr_addr),
    .write_req_i  (write_req),
    .fifo_full_i  (fifo_full),
    .fifo_empty_i (fifo_empty),
    .read_enb_i   (read_enb),
    .addr_o       (addr_sel),
    .write_enb_o  (write_enb),
    .vld_out_o    (vld_out),
    .soft_reset_o (soft_reset),
    .full_sel_o   (full_sel),
    .empty_sel_o  (empty_sel),
    .srst_sel_o   (srst_sel)
  );

  // The latched address is consumed inside the helper; kept visible here
  // for debug probing only.
  logic unused_addr;
  assign unused_addr = ^addr_sel;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_ctrl
// Directed bench for router_pkt_ctrl. Stimulus pushes the FIFO writes and
// soft-reset pulses it expects into a queue; a monitor pops and compares
// each time the DUT raises write_enb or soft_reset. State/busy decodes are
// checked directly at the falling edge. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_router_pkt_ctrl;

  localparam int NP = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          pkt_valid;
  logic [7:0]    data_in;
  logic          parity_done;
  logic          low_pkt_valid;
  logic [NP-1:0] fifo_full;
  logic [NP-1:0] fifo_empty;
  logic [NP-1:0] read_enb;
  logic [NP-1:0] write_enb;
  logic          ifd_state;
  logic [NP-1:0] soft_reset;
  logic [NP-1:0] vld_out;
  logic          fifo_full_sel;
  logic          busy;
  logic          detect_add;
  logic          ld_state;
  logic          laf_state;
  logic          full_state;
  logic          lp_state;
  logic          rst_int_reg;

  router_pkt_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .read_enb      (read_enb),
    .write_enb     (write_enb),
    .ifd_state     (ifd_state),
    .soft_reset    (soft_reset),
    .vld_out       (vld_out),
    .fifo_full_sel (fifo_full_sel),
    .busy          (busy),
    .detect_add    (detect_add),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .lp_state      (lp_state),
    .rst_int_reg   (rst_int_reg)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] we;
    logic       ifd;
    logic [2:0] sr;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;

`ifdef ROUTER_CTRL_WATCHDOG_EN
  localparam logic [2:0] EXP_PULSE = 3'b010;
`else
  localparam logic [2:0] EXP_PULSE = 3'b000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic push(input logic [2:0] we, input logic ifd, input logic [2:0] sr);
    ev_t e;
    e.we  = we;
    e.ifd = ifd;
    e.sr  = sr;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  // Scoreboard monitor: every write or soft-reset cycle must match the
  // next expected event in order.
  initial begin
    ev_t act;
    ev_t exp;
    forever begin
      @(negedge clock);
      if (mon_en && ((write_enb != 3'b000) || (soft_reset != 3'b000))) begin
        act.we  = write_enb;
        act.ifd = ifd_state;
        act.sr  = soft_reset;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got we=%b ifd=%b sr=%b, required no output",
                   write_enb, ifd_state, soft_reset);
        end else begin
          exp = exp_q.pop_front();
          check("scoreboard{we,ifd,sr}", 32'(act), 32'(exp));
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    pkt_valid     = 1'b0;
    data_in       = 8'h00;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
    fifo_full     = 3'b000;
    fifo_empty    = 3'b111;
    read_enb      = 3'b000;

    // ---- 1: reset ----
    tick();
    tick();
    settle();
    check("t1_detect_add", 32'(detect_add), 32'd1);
    check("t1_write_enb", 32'(write_enb), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_soft_reset", 32'(soft_reset), 32'd0);
    check("t1_vld_out", 32'(vld_out), 32'd0);
    mon_en = 1'b1;

    // ---- 2: packet to port 1, header + 4 payload writes + parity ----
    tick();
    reset     = 1'b0;
    pkt_valid = 1'b1;
    data_in   = 8'h05;
    push(3'b010, 1'b1, 3'b000);
    for (int i = 0; i < 5; i++) push(3'b010, 1'b0, 3'b000);
    tick();                       // LOAD_FIRST_DATA
    data_in = 8'h11;
    settle();
    check("t2_lfd_ifd", 32'(ifd_state), 32'd1);
    check("t2_lfd_busy", 32'(busy), 32'd1);
    tick();                       // LOAD_DATA #1
    data_in = 8'h12;
    settle();
    check("t2_ld_state", 32'(ld_state), 32'd1);
    check("t2_ld_busy", 32'(busy), 32'd0);
    tick();                       // LOAD_DATA #2
    data_in = 8'h13;
    tick();                       // LOAD_DATA #3
    data_in = 8'h14;
    tick();                       // LOAD_DATA #4, source drops pkt_valid
    pkt_valid = 1'b0;
    data_in   = 8'hab;
    tick();                       // LOAD_PARITY
    settle();
    check("t2_lp_state", 32'(lp_state), 32'd1);
    tick();                       // CHECK_PARITY_ERROR
    settle();
    check("t2_rst_int_reg", 32'(rst_int_reg), 32'd1);
    tick();                       // DECODE_ADDRESS
    settle();
    check("t2_end_detect_add", 32'(detect_add), 32'd1);
    check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

    // ---- 3: port 2 not empty -> WAIT_TILL_EMPTY ----
    tick();
    fifo_empty = 3'b011;
    pkt_valid  = 1'b1;
    data_in    = 8'h02;
    tick();                       // WAIT_TILL_EMPTY
    settle();
    check("t3_wait_busy", 32'(busy), 32'd1);
    check("t3_wait_not_decode", 32'(detect_add), 32'd0);
    tick();
    tick();
    tick();
    settle();
    check("t3_still_waiting", 32'(write_enb), 32'd0);
    tick();
    fifo_empty = 3'b111;
    push(3'b100, 1'b1, 3'b000);
    push(3'b100, 1'b0, 3'b000);
    push(3'b100, 1'b0, 3'b000);
    tick();                       // LOAD_FIRST_DATA
    tick();                       // LOAD_DATA
    pkt_valid = 1'b0;
    tick();                       // LOAD_PARITY
    tick();                       // CHECK_PARITY_ERROR
    tick();                       // DECODE_ADDRESS
    settle();
    check("t3_end_detect_add", 32'(detect_add), 32'd1);
    check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // ---- 4: FIFO 0 fills mid-payload, recovers with low_pkt_valid ----
    tick();
    pkt_valid = 1'b1;
    data_in   = 8'h10;
    push(3'b001, 1'b1, 3'b000);   // header
    push(3'b001, 1'b0, 3'b000);   // one payload byte before full
    push(3'b001, 1'b0, 3'b000);   // LOAD_AFTER_FULL
    push(3'b001, 1'b0, 3'b000);   // LOAD_PARITY
    tick();                       // LOAD_FIRST_DATA
    data_in = 8'h21;
    tick();                       // LOAD_DATA, written
    data_in = 8'h22;
    tick();                       // LOAD_DATA, FIFO now full
    fifo_full = 3'b001;
    settle();
    check("t4_ld_full_no_write", 32'(write_enb), 32'd0);
    check("t4_full_sel", 32'(fifo_full_sel), 32'd1);
    tick();                       // FIFO_FULL_STATE
    settle();
    check("t4_full_state", 32'(full_state), 32'd1);
    check("t4_full_busy", 32'(busy), 32'd1);
    check("t4_full_no_write", 32'(write_enb), 32'd0);
    tick();
    fifo_full     = 3'b000;
    pkt_valid     = 1'b0;
    low_pkt_valid = 1'b1;
    tick();                       // LOAD_AFTER_FULL
    settle();
    check("t4_laf_state", 32'(laf_state), 32'd1);
    tick();                       // LOAD_PARITY
    low_pkt_valid = 1'b0;
    settle();
    check("t4_lp_state", 32'(lp_state), 32'd1);
    tick();                       // CHECK_PARITY_ERROR
    tick();                       // DECODE_ADDRESS
    settle();
    check("t4_end_detect_add", 32'(detect_add), 32'd1);
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

    // ---- reset mid-packet ----
    tick();
    pkt_valid = 1'b1;
    data_in   = 8'h02;
    push(3'b100, 1'b1, 3'b000);
    push(3'b100, 1'b0, 3'b000);
    push(3'b100, 1'b0, 3'b000);
    tick();                       // LOAD_FIRST_DATA
    tick();                       // LOAD_DATA
    tick();                       // LOAD_DATA, reset sampled on next edge
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    pkt_valid = 1'b0;
    settle();
    check("trst_detect_add", 32'(detect_add), 32'd1);
    check("trst_write_enb", 32'(write_enb), 32'd0);
    check("trst_queue_drained", 32'(exp_q.size()), 32'd0);

    // ---- 6: header address 3 is dropped ----
    tick();
    pkt_valid = 1'b1;
    data_in   = 8'h07;
    tick();
    settle();
    check("t6_detect_add", 32'(detect_add), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_write_enb", 32'(write_enb), 32'd0);
    tick();
    pkt_valid = 1'b0;

    // ---- 5: watchdog on port 1 ----
    tick();
    fifo_empty = 3'b101;
    if (EXP_PULSE != 3'b000) push(3'b000, 1'b0, EXP_PULSE);
    settle();
    check("t5_vld_out", 32'(vld_out), 32'h2);
    for (int i = 1; i <= 31; i++) begin
      tick();
      settle();
      if (i == 29) check("t5_no_pulse_c29", 32'(soft_reset), 32'd0);
      if (i == 30) check("t5_pulse_c30", 32'(soft_reset), 32'(EXP_PULSE));
      if (i == 31) check("t5_pulse_one_cycle", 32'(soft_reset), 32'd0);
    end
    check("t5_fsm_unmoved", 32'(detect_add), 32'd1);
    tick();
    fifo_empty = 3'b111;
    tick();
    tick();
    fifo_empty = 3'b101;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 29) read_enb = 3'b010;   // read lands on the terminal cycle
      if (i == 30) read_enb = 3'b000;
      settle();
      if (i == 30) check("t5_read_suppresses", 32'(soft_reset), 32'd0);
      if (i == 31) check("t5_read_no_late_pulse", 32'(soft_reset), 32'd0);
    end
    tick();
    fifo_empty = 3'b111;
    tick();
    tick();
    settle();
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
